// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: ALU control-word bit indices, status-flag bit
// indices and the sequencer FSM state encoding.
package alu_sequencer_pkg;

  // ALU control-word bit indices (bits 9..13 are reserved and passed through untouched)
  localparam int unsigned ALU_OP_ADD    = 0;
  localparam int unsigned ALU_OP_SUB    = 1;
  localparam int unsigned ALU_OP_MUL    = 2;
  localparam int unsigned ALU_OP_DIV    = 3;
  localparam int unsigned ALU_OP_AND    = 4;
  localparam int unsigned ALU_OP_OR     = 5;
  localparam int unsigned ALU_OP_XOR    = 6;
  localparam int unsigned ALU_USE_CARRY = 7;
  localparam int unsigned ALU_NO_WR     = 8;

  // Status-flag bit indices
  localparam int unsigned STAT_CF = 0;
  localparam int unsigned STAT_PF = 1;
  localparam int unsigned STAT_ZF = 2;
  localparam int unsigned STAT_SF = 3;
  localparam int unsigned STAT_OF = 4;

  typedef enum logic [1:0] {
    SeqIdle = 2'd0,
    SeqLo   = 2'd1,
    SeqHi   = 2'd2,
    SeqRsp  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_flag_merge.sv
// Combines the flags of the low and high 32-bit passes of a wide operation into the flags of
// the whole 64-bit result.
//   lo_stat_i : flags from the low-word pass
//   hi_stat_i : flags from the high-word pass
//   merged_o  : CF/SF/OF from the high pass, PF from the low pass, ZF set only if both halves
//               were zero
module alu_flag_merge
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned STAT_W = 5
) (
  input  logic [STAT_W-1:0] lo_stat_i,
  input  logic [STAT_W-1:0] hi_stat_i,
  output logic [STAT_W-1:0] merged_o
);

  // Only PF and ZF of the low pass contribute
  logic unused_lo;
  assign unused_lo = ^lo_stat_i;

  always_comb begin
    merged_o          = hi_stat_i;
    merged_o[STAT_PF] = lo_stat_i[STAT_PF];
    merged_o[STAT_ZF] = lo_stat_i[STAT_ZF] & hi_stat_i[STAT_ZF];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller in front of the combinational ALU. Owns the architectural flags
// register, runs narrow ops in one ALU pass and wide ADD/AND/OR/XOR in two chained passes.
//   clk, rst                       : clock, asynchronous active-high reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_cntl/req_wide/req_opnd0/1  : operation, 64-bit flag, operands
//   rsp_valid/rsp_ready            : response handshake
//   rsp_result/rsp_status          : 64-bit result and flags of the op
//   status_q                       : architectural flags register
//   status_ld/status_ld_val        : external flag load, wins over an op commit
//   alu_*                          : drive to / results from the external ALU
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned CNTL_W = 14,
  parameter int unsigned STAT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CNTL_W-1:0] req_cntl,
  input  logic              req_wide,
  input  logic [63:0]       req_opnd0,
  input  logic [63:0]       req_opnd1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_result,
  output logic [STAT_W-1:0] rsp_status,
  output logic [STAT_W-1:0] status_q,
  input  logic              status_ld,
  input  logic [STAT_W-1:0] status_ld_val,
  output logic [CNTL_W-1:0] alu_cntl,
  output logic [STAT_W-1:0] alu_status_in,
  output logic [31:0]       alu_opnd0,
  output logic [31:0]       alu_opnd1,
  input  logic [STAT_W-1:0] alu_status_out,
  input  logic [31:0]       alu_result
);

  seq_state_e        state_q, state_d;
  logic [CNTL_W-1:0] cntl_q, cntl_d;
  logic [63:0]       opnd0_q, opnd0_d;
  logic [63:0]       opnd1_q, opnd1_d;
  logic              wide_q, wide_d;
  logic [63:0]       res_q, res_d;
  logic [STAT_W-1:0] work_stat_q, work_stat_d;
  logic [STAT_W-1:0] rsp_stat_q, rsp_stat_d;
  logic [STAT_W-1:0] status_d;
  logic [STAT_W-1:0] merged_stat;
  logic              wide_op;
  logic              no_wr;

  // Only ops whose high word depends on nothing but the high operands and the low carry chain
  assign wide_op = req_cntl[ALU_OP_ADD] | req_cntl[ALU_OP_AND] |
                   req_cntl[ALU_OP_OR]  | req_cntl[ALU_OP_XOR];
  assign no_wr   = cntl_q[ALU_NO_WR];

  alu_flag_merge #(
    .STAT_W (STAT_W)
  ) u_flag_merge (
    .lo_stat_i (work_stat_q),
    .hi_stat_i (alu_status_out),
    .merged_o  (merged_stat)
  );

  assign req_ready  = (state_q == SeqIdle);
  assign rsp_valid  = (state_q == SeqRsp);
  assign rsp_result = res_q;
  assign rsp_status = rsp_stat_q;

  always_comb begin
    state_d       = state_q;
    cntl_d        = cntl_q;
    opnd0_d       = opnd0_q;
    opnd1_d       = opnd1_q;
    wide_d        = wide_q;
    res_d         = res_q;
    work_stat_d   = work_stat_q;
    rsp_stat_d    = rsp_stat_q;
    status_d      = status_q;
    alu_cntl      = '0;
    alu_status_in = '0;
    alu_opnd0     = '0;
    alu_opnd1     = '0;

    unique case (state_q)
      SeqIdle: begin
        if (req_valid) begin
          cntl_d  = req_cntl;
          opnd0_d = req_opnd0;
          opnd1_d = req_opnd1;
          wide_d  = req_wide & wide_op;
          state_d = SeqLo;
        end
      end
      SeqLo: begin
        alu_cntl      = cntl_q;
        alu_status_in = status_q;
        alu_opnd0     = opnd0_q[31:0];
        alu_opnd1     = opnd1_q[31:0];
        // The low half of a wide op never consumes a stale carry
        if (wide_q) begin
          alu_cntl[ALU_USE_CARRY] = 1'b0;
        end
        res_d[31:0] = alu_result;
        work_stat_d = alu_status_out;
        if (wide_q) begin
          state_d = SeqHi;
        end else begin
          res_d      = no_wr ? 64'h0 : {32'h0, alu_result};
          rsp_stat_d = alu_status_out;
          if (!no_wr) begin
            status_d = alu_status_out;
          end
          state_d = SeqRsp;
        end
      end
      SeqHi: begin
        alu_cntl                = cntl_q;
        alu_cntl[ALU_USE_CARRY] = cntl_q[ALU_OP_ADD];
        alu_status_in           = work_stat_q;
        alu_opnd0               = opnd0_q[63:32];
        alu_opnd1               = opnd1_q[63:32];
        res_d      = no_wr ? 64'h0 : {alu_result, res_q[31:0]};
        rsp_stat_d = merged_stat;
        if (!no_wr) begin
          status_d = merged_stat;
        end
        state_d = SeqRsp;
      end
      SeqRsp: begin
        if (rsp_ready) begin
          state_d = SeqIdle;
        end
      end
      default: state_d = SeqIdle;
    endcase

    // External load takes priority over an op commit in the same cycle
    if (status_ld) begin
      status_d = status_ld_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SeqIdle;
      cntl_q      <= '0;
      opnd0_q     <= '0;
      opnd1_q     <= '0;
      wide_q      <= 1'b0;
      res_q       <= '0;
      work_stat_q <= '0;
      rsp_stat_q  <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cntl_q      <= cntl_d;
      opnd0_q     <= opnd0_d;
      opnd1_q     <= opnd1_d;
      wide_q      <= wide_d;
      res_q       <= res_d;
      work_stat_q <= work_stat_d;
      rsp_stat_q  <= rsp_stat_d;
      status_q    <= status_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_cntl;
  logic        req_wide;
  logic [63:0] req_opnd0;
  logic [63:0] req_opnd1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [4:0]  rsp_status;
  logic [4:0]  status_q;
  logic        status_ld;
  logic [4:0]  status_ld_val;
  logic [13:0] alu_cntl;
  logic [4:0]  alu_status_in;
  logic [31:0] alu_opnd0;
  logic [31:0] alu_opnd1;
  logic [4:0]  alu_status_out;
  logic [31:0] alu_result;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  int op_tab[7] = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_MUL, ALU_OP_DIV,
                    ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR};

  alu_sequencer #(
    .CNTL_W (14),
    .STAT_W (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cntl       (req_cntl),
    .req_wide       (req_wide),
    .req_opnd0      (req_opnd0),
    .req_opnd1      (req_opnd1),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_status     (rsp_status),
    .status_q       (status_q),
    .status_ld      (status_ld),
    .status_ld_val  (status_ld_val),
    .alu_cntl       (alu_cntl),
    .alu_status_in  (alu_status_in),
    .alu_opnd0      (alu_opnd0),
    .alu_opnd1      (alu_opnd1),
    .alu_status_out (alu_status_out),
    .alu_result     (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] mk_flags(input logic cf, input logic [7:0] lowbyte,
                                          input logic zf, input logic sf, input logic of);
    logic [4:0] f;
    f = '0;
    f[STAT_CF] = cf;
    f[STAT_PF] = ~^lowbyte;
    f[STAT_ZF] = zf;
    f[STAT_SF] = sf;
    f[STAT_OF] = of;
    return f;
  endfunction

  // 32-bit combinational ALU standing in for the real one
  function automatic logic [36:0] alu_fn(input logic [13:0] c, input logic [4:0] si,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] r;
    logic        cf;
    logic        of;
    cf = 1'b0;
    of = 1'b0;
    r  = '0;
    if (c[ALU_OP_ADD]) begin
      s  = {1'b0, a} + {1'b0, b} + {32'd0, c[ALU_USE_CARRY] & si[STAT_CF]};
      r  = s[31:0];
      cf = s[32];
      of = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (c[ALU_OP_SUB]) begin
      r  = a - b;
      cf = a < b;
      of = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (c[ALU_OP_MUL]) begin
      p  = {32'd0, a} * {32'd0, b};
      r  = p[31:0];
      cf = |p[63:32];
      of = cf;
    end else if (c[ALU_OP_DIV]) begin
      r = (b == 32'd0) ? 32'd0 : a / b;
    end else if (c[ALU_OP_AND]) begin
      r = a & b;
    end else if (c[ALU_OP_OR]) begin
      r = a | b;
    end else if (c[ALU_OP_XOR]) begin
      r = a ^ b;
    end
    return {mk_flags(cf, r[7:0], r == 32'd0, r[31], of), r};
  endfunction

  assign {alu_status_out, alu_result} = alu_fn(alu_cntl, alu_status_in, alu_opnd0, alu_opnd1);

  function automatic logic is_wide(input logic [13:0] c, input logic w);
    return w && (c[ALU_OP_ADD] || c[ALU_OP_AND] || c[ALU_OP_OR] || c[ALU_OP_XOR]);
  endfunction

  // Whole-operation reference: {flags, 64-bit result} straight from 64-bit arithmetic
  function automatic logic [68:0] model_op(input logic [13:0] c, input logic w,
                                           input logic [63:0] a_in, input logic [63:0] b_in,
                                           input logic [4:0] st);
    logic        we;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] s;
    logic [63:0] p;
    logic [63:0] r;
    logic        cf;
    logic        of;
    logic        sf;
    we = is_wide(c, w);
    a  = we ? a_in : {32'd0, a_in[31:0]};
    b  = we ? b_in : {32'd0, b_in[31:0]};
    cf = 1'b0;
    of = 1'b0;
    r  = '0;
    if (c[ALU_OP_ADD]) begin
      s = {1'b0, a} + {1'b0, b} + {64'd0, !we && c[ALU_USE_CARRY] && st[STAT_CF]};
      if (we) begin
        r  = s[63:0];
        cf = s[64];
        of = (a[63] == b[63]) && (r[63] != a[63]);
      end else begin
        r  = {32'd0, s[31:0]};
        cf = s[32];
        of = (a[31] == b[31]) && (r[31] != a[31]);
      end
    end else if (c[ALU_OP_SUB]) begin
      r  = {32'd0, a[31:0] - b[31:0]};
      cf = a[31:0] < b[31:0];
      of = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (c[ALU_OP_MUL]) begin
      p  = a * b;
      r  = {32'd0, p[31:0]};
      cf = |p[63:32];
      of = cf;
    end else if (c[ALU_OP_DIV]) begin
      r = (b == 64'd0) ? 64'd0 : a / b;
    end else if (c[ALU_OP_AND]) begin
      r = a & b;
    end else if (c[ALU_OP_OR]) begin
      r = a | b;
    end else if (c[ALU_OP_XOR]) begin
      r = a ^ b;
    end
    sf = we ? r[63] : r[31];
    return {mk_flags(cf, r[7:0], r == 64'd0, sf, of), r};
  endfunction

  // Transaction-level model: busy flag, cycles left, pending response, flags register
  logic        m_busy;
  int          m_left;
  logic        m_rsp_valid;
  logic [63:0] m_result;
  logic [4:0]  m_rstat;
  logic [4:0]  m_status;
  logic [13:0] op_c;
  logic        op_w;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [68:0] mres;

  assign mres = model_op(op_c, op_w, op_a, op_b, m_status);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy      <= 1'b0;
      m_left      <= 0;
      m_rsp_valid <= 1'b0;
      m_result    <= '0;
      m_rstat     <= '0;
      m_status    <= '0;
      op_c        <= '0;
      op_w        <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
    end else begin
      if (m_busy && m_rsp_valid) begin
        if (rsp_ready) begin
          m_busy      <= 1'b0;
          m_rsp_valid <= 1'b0;
        end
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_rsp_valid <= 1'b1;
          m_rstat     <= mres[68:64];
          m_result    <= op_c[ALU_NO_WR] ? 64'd0 : mres[63:0];
          if (!op_c[ALU_NO_WR]) m_status <= mres[68:64];
        end
      end else if (req_valid) begin
        m_busy <= 1'b1;
        m_left <= is_wide(req_cntl, req_wide) ? 2 : 1;
        op_c   <= req_cntl;
        op_w   <= req_wide;
        op_a   <= req_opnd0;
        op_b   <= req_opnd1;
      end
      if (status_ld) m_status <= status_ld_val;
    end
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 64'(req_ready), 64'(!m_busy));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
      check("status_q", 64'(status_q), 64'(m_status));
      if (m_rsp_valid) begin
        check("rsp_result", rsp_result, m_result);
        check("rsp_status", 64'(rsp_status), 64'(m_rstat));
      end
      if (!m_busy) begin
        check("alu_cntl_idle", 64'(alu_cntl), 64'd0);
        check("alu_stat_idle", 64'(alu_status_in), 64'd0);
        check("alu_opnd_idle", {alu_opnd1, alu_opnd0}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [13:0] c, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    int n;
    n         = 0;
    req_cntl  = c;
    req_wide  = w;
    req_opnd0 = a;
    req_opnd1 = b;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) check("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_random();
    int   n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 60) begin
      rsp_ready     = ($urandom_range(0, 2) != 0);
      status_ld     = ($urandom_range(0, 7) == 0);
      status_ld_val = 5'($urandom);
      req_valid     = ($urandom_range(0, 1) == 1);
      req_cntl      = 14'($urandom);
      req_wide      = 1'($urandom);
      req_opnd0     = {$urandom, $urandom};
      req_opnd1     = {$urandom, $urandom};
      @(negedge clk);
      hs = rsp_valid && rsp_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    status_ld = 1'b0;
    rsp_ready = 1'b1;
    if (!hs) check("drain_timeout", 64'(hs), 64'd1);
  endtask

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  logic [13:0] c_add;
  logic [13:0] c_and_nowr;
  logic [13:0] c_xor;
  logic [13:0] c_rnd;
  int          lat;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_cntl = '0;
    req_wide = 1'b0;
    req_opnd0 = '0;
    req_opnd1 = '0;
    rsp_ready = 1'b1;
    status_ld = 1'b0;
    status_ld_val = '0;
    c_add = '0;
    c_add[ALU_OP_ADD] = 1'b1;
    c_and_nowr = '0;
    c_and_nowr[ALU_OP_AND] = 1'b1;
    c_and_nowr[ALU_NO_WR] = 1'b1;
    c_xor = '0;
    c_xor[ALU_OP_XOR] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_status_q", 64'(status_q), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    @(posedge clk);
    #1;

    // Narrow ADD wrapping to zero
    issue(c_add, 1'b0, 64'hFFFF_FFFF, 64'h1);
    wait_rsp(lat);
    check("narrow_lat", 64'(lat), 64'd2);
    check("narrow_res", rsp_result, 64'd0);
    check("narrow_stat", 64'(rsp_status), 64'b00111);
    check("narrow_status_q", 64'(status_q), 64'b00111);
    handshake();

    // Wide ADD, carry out of the low word into the high word
    issue(c_add, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1);
    wait_rsp(lat);
    check("wide_lat", 64'(lat), 64'd3);
    check("wide_res", rsp_result, 64'h0000_0001_0000_0000);
    check("wide_stat", 64'(rsp_status), 64'b00010);
    handshake();

    // Wide ADD wrapping all 64 bits
    issue(c_add, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_rsp(lat);
    check("wide_wrap_res", rsp_result, 64'd0);
    check("wide_wrap_stat", 64'(rsp_status), 64'b00111);
    handshake();

    // NO_WR leaves the flags register alone and returns a zero result
    status_ld = 1'b1;
    status_ld_val = 5'b10101;
    @(posedge clk);
    #1;
    status_ld = 1'b0;
    issue(c_and_nowr, 1'b0, 64'hFF, 64'h0F);
    wait_rsp(lat);
    check("nowr_res", rsp_result, 64'd0);
    check("nowr_stat", 64'(rsp_status), 64'b00010);
    check("nowr_status_q", 64'(status_q), 64'b10101);
    handshake();

    // Response back-pressure with a second request waiting
    rsp_ready = 1'b0;
    issue(c_xor, 1'b0, 64'hF0F0_F0F0, 64'h0F0F_0F0F);
    req_cntl = c_add;
    req_wide = 1'b0;
    req_opnd0 = 64'd2;
    req_opnd1 = 64'd3;
    req_valid = 1'b1;
    wait_rsp(lat);
    repeat (4) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_res", rsp_result, 64'hFFFF_FFFF);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(c_add, 1'b0, 64'd2, 64'd3);
    wait_rsp(lat);
    check("bp_second_res", rsp_result, 64'd5);
    handshake();

    // External flag load coinciding with the commit edge
    issue(c_add, 1'b0, 64'hFFFF_FFFF, 64'h1);
    status_ld = 1'b1;
    status_ld_val = 5'b00001;
    @(posedge clk);
    #1;
    status_ld = 1'b0;
    @(negedge clk);
    check("ld_commit_valid", 64'(rsp_valid), 64'd1);
    check("ld_commit_status_q", 64'(status_q), 64'b00001);
    check("ld_commit_rsp_stat", 64'(rsp_status), 64'b00111);
    handshake();

    // Reset while the high pass is running
    issue(c_add, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_hi_valid", 64'(rsp_valid), 64'd0);
    check("rst_hi_ready", 64'(req_ready), 64'd1);
    check("rst_hi_status_q", 64'(status_q), 64'd0);
    check("rst_hi_result", rsp_result, 64'd0);
    check("rst_hi_alu", 64'(alu_cntl), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Randomised operations against the model
    for (int i = 0; i < 300; i++) begin
      c_rnd = '0;
      c_rnd[op_tab[$urandom_range(0, 6)]] = 1'b1;
      c_rnd[ALU_USE_CARRY] = 1'($urandom);
      c_rnd[ALU_NO_WR] = ($urandom_range(0, 4) == 0);
      c_rnd[13:9] = 5'($urandom);
      issue(c_rnd, 1'($urandom), {rword(), rword()}, {rword(), rword()});
      drain_random();
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
